// File: rtl/fx3_slfifo_tx.sv
// fx3_slfifo_tx: AXI-style stream to FX3 slave-FIFO write cycles.
// Registered outputs give one cycle of latency. Bursts are capped at
// BURST_MAX words, with a FULL_LAT-cycle gap after each capped burst.
// A flush request sends a zero-length packet (ZLP) once the stream is idle.
// Free-running counters report words written and packet-end strobes.
module fx3_slfifo_tx #(
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_MAX = 256,
  parameter int unsigned FULL_LAT  = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    stream_s_data_i,
  input  logic             stream_s_valid_i,
  input  logic             stream_s_last_i,
  output logic             stream_s_ready_o,
  input  logic             flush_i,
  output logic             fx3_wr_o,
  output logic [DW-1:0]    fx3_data_o,
  output logic             fx3_pktend_o,
  input  logic             fx3_full_i,
  output logic [CNT_W-1:0] tx_words_o,
  output logic [CNT_W-1:0] tx_pkts_o
);

  localparam logic [16:0] BURST_LIM = 17'(BURST_MAX);
  localparam logic [3:0]  GAP_LAST  = 4'(FULL_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_ZLP
  } state_t;

  state_t           state_q, state_d;
  logic             full_q, full_d;
  logic [15:0]      burst_q, burst_d;
  logic [3:0]       gap_q, gap_d;
  logic             flush_q, flush_d;
  logic             wr_q, wr_d;
  logic             pktend_q, pktend_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;

  logic             ready;
  logic             xfer;
  logic [16:0]      burst_inc;

  // Ready comes only from registered state, so there is no input-to-ready path.
  assign ready = (state_q == ST_RUN) && !full_q;
  assign xfer  = stream_s_valid_i && ready;

  // Next-state, burst/gap counting, flush tracking and output staging.
  always_comb begin
    state_d   = state_q;
    full_d    = fx3_full_i;
    burst_d   = burst_q;
    gap_d     = gap_q;
    flush_d   = flush_q || flush_i;
    wr_d      = 1'b0;
    pktend_d  = 1'b0;
    data_d    = data_q;
    burst_inc = {1'b0, burst_q} + 17'd1;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          wr_d     = 1'b1;
          data_d   = stream_s_data_i;
          pktend_d = stream_s_last_i;
          // Reaching the burst cap wins over last for the next state; both
          // clear the counter, so a packet ending exactly at the cap still gaps.
          if (burst_inc == BURST_LIM) begin
            burst_d = '0;
            gap_d   = '0;
            state_d = ST_GAP;
          end else if (stream_s_last_i) begin
            burst_d = '0;
          end else begin
            burst_d = burst_inc[15:0];
          end
        end else if (flush_q && !full_q) begin
          // ZLP strobe is staged here so it lands in the ZLP state cycle;
          // any flush_i seen this cycle merges into the one being issued.
          pktend_d = 1'b1;
          flush_d  = 1'b0;
          state_d  = ST_ZLP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_ZLP: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status counters advance for each cycle the corresponding strobe is out.
  always_comb begin
    words_d = words_q;
    pkts_d  = pkts_q;
    if (wr_q) begin
      words_d = words_q + CNT_W'(1);
    end
    if (pktend_q) begin
      pkts_d = pkts_q + CNT_W'(1);
    end
  end

  // State and output registers; full_q resets high to block writes until sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      full_q   <= 1'b1;
      burst_q  <= '0;
      gap_q    <= '0;
      flush_q  <= 1'b0;
      wr_q     <= 1'b0;
      pktend_q <= 1'b0;
      data_q   <= '0;
      words_q  <= '0;
      pkts_q   <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      flush_q  <= flush_d;
      wr_q     <= wr_d;
      pktend_q <= pktend_d;
      data_q   <= data_d;
      words_q  <= words_d;
      pkts_q   <= pkts_d;
    end
  end

  assign stream_s_ready_o = ready;
  assign fx3_wr_o         = wr_q;
  assign fx3_data_o       = data_q;
  assign fx3_pktend_o     = pktend_q;
  assign tx_words_o       = words_q;
  assign tx_pkts_o        = pkts_q;

  // Upstream must hold data and last steady while a word waits for ready.
  a_stream_stable: assert property (
    @(posedge clk) disable iff (rst)
    (stream_s_valid_i && !stream_s_ready_o) |=>
      (!stream_s_valid_i || ($stable(stream_s_data_i) && $stable(stream_s_last_i)))
  );

endmodule

// File: tb/tb_fx3_slfifo_tx.sv
// Scoreboard bench for fx3_slfifo_tx: stimulus pushes expected FX3 events,
// a negedge monitor pops and compares every wr/pktend cycle.
module tb_fx3_slfifo_tx;
  localparam int unsigned DW = 32;
  localparam int unsigned BM = 4;
  localparam int unsigned FL = 3;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          flush = 1'b0;
  logic          wr;
  logic [DW-1:0] fdata;
  logic          pktend;
  logic          full = 1'b0;
  logic [CW-1:0] words;
  logic [CW-1:0] pkts;

  always #5 clk = ~clk;

  fx3_slfifo_tx #(.DW(DW), .BURST_MAX(BM), .FULL_LAT(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid),
    .stream_s_last_i(s_last), .stream_s_ready_o(s_ready),
    .flush_i(flush),
    .fx3_wr_o(wr), .fx3_data_o(fdata), .fx3_pktend_o(pktend),
    .fx3_full_i(full),
    .tx_words_o(words), .tx_pkts_o(pkts)
  );

  typedef struct packed {
    logic          zlp;
    logic          last;
    logic [DW-1:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic        wr_log[$];
  logic        rdy_log[$];
  int unsigned exp_pat[$];
  bit          log_en = 1'b0;
  bit          done = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_words = 0;
  int unsigned exp_pkts = 0;
  int unsigned hs_cnt = 0;
  logic [1:0]  fh;
  time         zlp_time = 0;
  time         full_fall_time = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // full_i history sampled at the clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) fh <= '0;
    else     fh <= {fh[0], full};
  end

  // Monitor: pops the expected event whenever the DUT shows wr or pktend.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (log_en) begin
        wr_log.push_back(wr);
        rdy_log.push_back(s_ready);
      end
      if (fh[1]) check("full_blocks_output", 64'({wr, pktend}), 64'd0);
      if (wr || pktend) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({wr, pktend}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.zlp) begin
            check("zlp_wr", 64'(wr), 64'd0);
            check("zlp_pktend", 64'(pktend), 64'd1);
            zlp_time = $time;
          end else begin
            check("word_wr", 64'(wr), 64'd1);
            check("word_data", 64'(fdata), 64'(e.data));
            check("word_pktend", 64'(pktend), 64'(e.last));
          end
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until the handshake edge has passed.
  task automatic send_word(input logic [DW-1:0] d, input logic l,
                           input int unsigned pre_idle, input bit raise_full);
    int unsigned t;
    logic r;
    s_valid = 1'b0;
    step(pre_idle);
    exp_q.push_back('{zlp: 1'b0, last: l, data: d});
    exp_words++;
    if (l) exp_pkts++;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      r = s_ready;
      if (r && raise_full) full = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 200);
    if (!r) check("handshake_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    hs_cnt++;
  endtask

  // Expected wr pattern for a packet of n words with valid held and full low.
  task automatic make_pattern(input int unsigned n);
    int unsigned c;
    exp_pat.delete();
    c = 0;
    for (int unsigned i = 0; i < n; i++) begin
      exp_pat.push_back(1);
      c++;
      if (c == BM) begin
        for (int unsigned g = 0; g < FL; g++) exp_pat.push_back(0);
        c = 0;
      end else if (i == n - 1) begin
        c = 0;
      end
    end
  endtask

  task automatic check_pattern(input string name, input bit use_rdy);
    logic [63:0] act, req;
    int unsigned k, n, len;
    bit found;
    logic b;
    act = '0; req = '0; k = 0; found = 1'b0;
    n = exp_pat.size();
    len = use_rdy ? rdy_log.size() : wr_log.size();
    for (int unsigned i = 0; i < len; i++) begin
      b = use_rdy ? rdy_log[i] : wr_log[i];
      if (b) found = 1'b1;
      if (found && k < n) begin
        act[k] = b;
        k++;
      end
    end
    for (int unsigned i = 0; i < n; i++) req[i] = (exp_pat[i] != 0);
    check(name, act, req);
  endtask

  task automatic start_log();
    wr_log.delete();
    rdy_log.delete();
    log_en = 1'b1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_tx_words"}, 64'(words), 64'(exp_words));
    check({tag, "_tx_pkts"}, 64'(pkts), 64'(exp_pkts));
  endtask

  initial begin
    int unsigned base;
    int unsigned run;
    bit seen;
    int unsigned len;

    // Reset state
    step(3);
    check("reset_wr", 64'(wr), 64'd0);
    check("reset_pktend", 64'(pktend), 64'd0);
    check("reset_data", 64'(fdata), 64'd0);
    check("reset_ready", 64'(s_ready), 64'd0);
    check_counters("reset");

    // 1: 10-word packet from reset release, valid held high
    start_log();
    rst = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) send_word(DW'(i), (i == 10), 0, 1'b0);
    step(6);
    log_en = 1'b0;
    make_pattern(10);
    check_pattern("t1_wr_pattern", 1'b0);
    check_counters("t1");

    // 2: 9-word packet, gaps after every BM words
    start_log();
    for (int unsigned i = 1; i <= 9; i++) send_word(DW'(32'h200 + i), (i == 9), 0, 1'b0);
    step(6);
    log_en = 1'b0;
    make_pattern(9);
    check_pattern("t2_wr_pattern", 1'b0);
    check_pattern("t2_ready_pattern", 1'b1);
    check_counters("t2");

    // 3: full raised after the 2nd word, released 5 cycles later
    start_log();
    base = hs_cnt;
    fork
      for (int unsigned i = 1; i <= 8; i++) send_word(DW'(32'h300 + i), (i == 8), 0, 1'b0);
      begin
        wait (hs_cnt == base + 2);
        full = 1'b1;
        step(5);
        full = 1'b0;
      end
    join
    step(8);
    log_en = 1'b0;
    run = 0;
    seen = 1'b0;
    for (int unsigned i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i]) begin
        seen = 1'b1;
        run++;
      end else if (seen) begin
        break;
      end
    end
    check("t3_words_before_stall", 64'(run), 64'd3);
    check_counters("t3");

    // 4: flush while idle -> one ZLP two cycles after the pulse
    step(4);
    exp_q.push_back('{zlp: 1'b1, last: 1'b0, data: '0});
    exp_pkts++;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("t4_pktend_c1", 64'({wr, pktend}), 64'd0);
    @(negedge clk);
    check("t4_pktend_c2", 64'({wr, pktend}), 64'b01);
    @(negedge clk);
    check("t4_pktend_c3", 64'({wr, pktend}), 64'd0);
    step(4);
    check_counters("t4");

    // 5: two flushes during a 6-word packet, full high 4 cycles after it
    base = hs_cnt;
    zlp_time = 0;
    fork
      for (int unsigned i = 1; i <= 6; i++) send_word(DW'(32'h500 + i), (i == 6), 0, (i == 6));
      begin
        wait (hs_cnt == base + 1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait (hs_cnt == base + 3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
      end
    join
    exp_q.push_back('{zlp: 1'b1, last: 1'b0, data: '0});
    exp_pkts++;
    step(3);
    full = 1'b0;
    full_fall_time = $time;
    step(10);
    check("t5_zlp_after_full_fall", 64'(zlp_time > full_fall_time), 64'd1);
    check_counters("t5");

    // Random packets with random valid gaps and full toggling
    done = 1'b0;
    fork
      begin
        for (int unsigned p = 0; p < 20; p++) begin
          len = $urandom_range(1, 9);
          for (int unsigned i = 0; i < len; i++)
            send_word(DW'($urandom), (i == len - 1), $urandom_range(0, 2), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step(1);
          full = ($urandom_range(0, 3) == 0);
        end
        full = 1'b0;
      end
    join
    step(20);
    check("rand_queue_drained", 64'(exp_q.size()), 64'd0);
    check_counters("rand");

    // 6: reset at word 3 with a flush pending, then a fresh 32-bit packet
    send_word(DW'(32'h601), 1'b0, 2, 1'b0);
    send_word(DW'(32'h602), 1'b0, 0, 1'b0);
    flush = 1'b1;
    send_word(DW'(32'h603), 1'b0, 0, 1'b0);
    flush = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_wr", 64'(wr), 64'd0);
    check("t6_rst_pktend", 64'(pktend), 64'd0);
    check("t6_rst_data", 64'(fdata), 64'd0);
    check("t6_rst_ready", 64'(s_ready), 64'd0);
    exp_q.delete();
    exp_words = 0;
    exp_pkts = 0;
    check_counters("t6_rst");
    step(3);
    rst = 1'b0;
    send_word(DW'(32'hDEADBEEF), 1'b0, 1, 1'b0);
    send_word(DW'(32'h12345678), 1'b1, 0, 1'b0);
    step(10);
    check_counters("t6_after");
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
